char_spike_gen: RTL and testbench

//   Multi-pixel, parametrised successor of the single-output character PWM generator.
//   On a start request it presents one stored character as NUM_PIX parallel rate-coded spike trains.

---
 rtl/char_spike_pkg.sv | 40 ++++
 rtl/char_pattern_rom.sv | 35 +++
 rtl/char_spike_gen.sv | 140 ++++++++++++++
 tb/tb_char_spike_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/char_spike_pkg.sv
// rtl/char_spike_pkg.sv - shared types, default pattern ROM and LFSR helpers for char_spike_gen
package char_spike_pkg;

    localparam int DEF_NUM_PIX    = 9;
    localparam int DEF_NUM_CHARS  = 4;
    localparam int DEF_INT_W      = 4;
    localparam int DEF_NUM_FRAMES = 16;

    localparam int ROM_CHARS = 4;
    localparam int ROM_PIX   = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Pixel 0 first, row-major from the top-left corner.
    localparam logic [3:0] ROM_DEFAULT [ROM_CHARS][ROM_PIX] = '{
        '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0},
        '{4'hF, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h5},
        '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8},
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}
    };

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        int k;
        k = n % 16;
        return (v << k) | (v >> (16 - k));
    endfunction

endpackage

// File: rtl/char_pattern_rom.sv
// rtl/char_pattern_rom.sv - registered-read character intensity ROM
module char_pattern_rom
    import char_spike_pkg::*;
#(
    parameter int NUM_PIX   = DEF_NUM_PIX,
    parameter int NUM_CHARS = DEF_NUM_CHARS,
    parameter int INT_W     = DEF_INT_W,
    localparam int SEL_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [SEL_W-1:0]         index,
    output logic [NUM_PIX*INT_W-1:0] data
);

    logic [NUM_PIX*INT_W-1:0] table_q [NUM_CHARS];

    // Characters or pixels beyond the default table read as blank.
    for (genvar c = 0; c < NUM_CHARS; c++) begin : g_char
        for (genvar p = 0; p < NUM_PIX; p++) begin : g_pix
            if (c < ROM_CHARS && p < ROM_PIX) begin : g_def
                assign table_q[c][p*INT_W +: INT_W] = INT_W'(ROM_DEFAULT[c][p]);
            end else begin : g_blank
                assign table_q[c][p*INT_W +: INT_W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= table_q[index];
        end
    end

endmodule

// File: rtl/char_spike_gen.sv
// rtl/char_spike_gen.sv - multi-pixel rate-coded character spike generator
// Optional CHAR_SPIKE_LFSR_EN: LFSR stochastic coding replaces the PWM phase compare.
module char_spike_gen
    import char_spike_pkg::*;
#(
    parameter int NUM_PIX    = DEF_NUM_PIX,
    parameter int NUM_CHARS  = DEF_NUM_CHARS,
    parameter int INT_W      = DEF_INT_W,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    localparam int SEL_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
    localparam int FRM_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SEL_W-1:0]   char_select,
    output logic               busy,
    output logic               done,
    output logic [FRM_W-1:0]   frame_cnt,
    output logic [NUM_PIX-1:0] pix_out
);

    localparam int               PERIOD     = 2**INT_W - 1;
    localparam logic [INT_W-1:0] PHASE_LAST = INT_W'(PERIOD - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(NUM_FRAMES - 1);

    state_t                   state;
    logic [INT_W-1:0]         phase;
    logic [INT_W-1:0]         phase_nxt;
    logic [NUM_PIX*INT_W-1:0] rom_data;
    logic [NUM_PIX*INT_W-1:0] intens;
    logic [NUM_PIX-1:0]       cmp_load;
    logic [NUM_PIX-1:0]       cmp_run;

    // The ROM only captures in IDLE, so its output holds the character latched with start.
    char_pattern_rom #(
        .NUM_PIX  (NUM_PIX),
        .NUM_CHARS(NUM_CHARS),
        .INT_W    (INT_W)
    ) u_rom (
        .clk  (clk),
        .en   (state == IDLE),
        .index(char_select),
        .data (rom_data)
    );

    assign phase_nxt = (phase == PHASE_LAST) ? '0 : phase + 1'b1;

`ifdef CHAR_SPIKE_LFSR_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    function automatic logic [INT_W-1:0] rand_slice(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = rotl16(v, n);
        return r[INT_W-1:0];
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);

    // lfsr holds the value used for the pix_out currently on the outputs.
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) begin
            lfsr <= LFSR_SEED;
        end else if (state == RUN) begin
            lfsr <= lfsr_nxt;
        end
    end

    always_comb begin
        cmp_load = '0;
        cmp_run  = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            cmp_load[i] = rom_data[i*INT_W +: INT_W] > rand_slice(LFSR_SEED, i);
            cmp_run[i]  = intens[i*INT_W +: INT_W] > rand_slice(lfsr_nxt, i);
        end
    end
`else
    always_comb begin
        cmp_load = '0;
        cmp_run  = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            cmp_load[i] = rom_data[i*INT_W +: INT_W] != '0;
            cmp_run[i]  = intens[i*INT_W +: INT_W] > phase_nxt;
        end
    end
`endif

    // pix_out is registered, so each edge loads the value for the cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_out   <= '0;
            frame_cnt <= '0;
            phase     <= '0;
            intens    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    intens    <= rom_data;
                    phase     <= '0;
                    frame_cnt <= '0;
                    pix_out   <= cmp_load;
                    state     <= RUN;
                end
                RUN: begin
                    if (phase == PHASE_LAST && frame_cnt == FRAME_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pix_out <= '0;
                    end else begin
                        phase   <= phase_nxt;
                        pix_out <= cmp_run;
                        if (phase == PHASE_LAST) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    frame_cnt <= '0;
                    phase     <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_spike_gen.sv
// tb/tb_char_spike_gen.sv - scoreboard testbench for char_spike_gen
module tb_char_spike_gen;

    localparam int NP      = 9;
    localparam int P       = 15;
    localparam int RUN_CYC = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  char_select;
    logic        busy;
    logic        done;
    logic [3:0]  frame_cnt;
    logic [8:0]  pix_out;

    int n_tests = 0;
    int n_fail  = 0;
    int fire_cnt [NP];

    logic [8:0] exp_q [$];

    int tb_int [4][9] = '{
        '{0, 15, 0, 15, 15, 15, 0, 15, 0},
        '{15, 0, 0, 0, 10, 0, 0, 0, 5},
        '{8, 8, 8, 8, 8, 8, 8, 8, 8},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0}
    };

    always #5 clk = ~clk;

    char_spike_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_select(char_select),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt),
        .pix_out    (pix_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] m_rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [8:0] exp_pix(input int c, input int cyc, input logic [15:0] l);
        logic [8:0]  e;
        logic [15:0] rot;
        int          r;
        e = '0;
        for (int i = 0; i < NP; i++) begin
`ifdef CHAR_SPIKE_LFSR_EN
            rot = m_rotl(l, i);
            r   = int'(rot[3:0]);
`else
            rot = l;
            r   = cyc % P;
`endif
            e[i] = tb_int[c][i] > r;
        end
        return e;
    endfunction

    task automatic push_expected(input int c);
        logic [15:0] l;
        l = 16'hACE1;
        for (int cyc = 0; cyc < RUN_CYC; cyc++) begin
            exp_q.push_back(exp_pix(c, cyc, l));
            l = m_lfsr(l);
        end
    endtask

    // mode 0: plain run, 1: select switch and start pulse at frame 3, 2: reset in frame 5
    task automatic present(input int c, input int mode);
        logic [8:0] e;
        for (int i = 0; i < NP; i++) fire_cnt[i] = 0;
        char_select = 2'(c);
        start       = 1'b1;
        push_expected(c);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        check("load_pix", 32'(pix_out), 32'd0);
        for (int cyc = 0; cyc < RUN_CYC; cyc++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("pix", 32'(pix_out), 32'(e));
            check("frame", 32'(frame_cnt), 32'(cyc / P));
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            for (int i = 0; i < NP; i++) fire_cnt[i] += int'(pix_out[i]);
            if (mode == 1 && cyc == 45) begin
                char_select = 2'd0;
                start       = 1'b1;
            end
            if (mode == 1 && cyc == 46) start = 1'b0;
            if (mode == 2 && cyc == 77) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_pix", 32'(pix_out), 32'd0);
                check("rst_frame", 32'(frame_cnt), 32'd0);
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_pix", 32'(pix_out), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frame", 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        char_select = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pix", 32'(pix_out), 32'd0);
        check("reset_frame", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        present(1, 0);
        present(2, 1);
        present(3, 0);
        present(0, 2);
        present(0, 0);

`ifdef CHAR_SPIKE_LFSR_EN
        for (int run = 0; run < 2; run++) begin
            present(0, 0);
            for (int i = 0; i < NP; i++) begin
                if (tb_int[0][i] == 0) check("lfsr_silent", 32'(fire_cnt[i]), 32'd0);
                else check("lfsr_min_fire", 32'(fire_cnt[i] >= 200), 32'd1);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
